// File: rtl/show_mask_overlay_pkg.sv
// Shared definitions for the mask overlay: sensor frame geometry, grid colour,
// overlay mode encodings and the RGB565 blend helper.
package show_mask_overlay_pkg;

    localparam int          OV5640_X   = 640;
    localparam int          OV5640_Y   = 480;
    localparam logic [15:0] GRID_COLOR = 16'hFFFF;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_REPLACE = 2'd1,
        MODE_BLEND   = 2'd2,
        MODE_SOLID   = 2'd3
    } ovl_mode_e;

    // Per-field average of two RGB565 pixels, rounding down.
    function automatic logic [15:0] avg565(input logic [15:0] a, input logic [15:0] b);
        logic [5:0] r_s;
        logic [6:0] g_s;
        logic [5:0] b_s;
        r_s = {1'b0, a[15:11]} + {1'b0, b[15:11]};
        g_s = {1'b0, a[10:5]}  + {1'b0, b[10:5]};
        b_s = {1'b0, a[4:0]}   + {1'b0, b[4:0]};
        return {r_s[5:1], g_s[6:1], b_s[5:1]};
    endfunction

endpackage

// File: rtl/show_mask_overlay_ram.sv
// Ping-pong mask store: simple dual-port RAM, one write and one registered read
// port on a single clock; the bank select is the address MSB.
module mask_pingpong_ram #(
    parameter int AW = 5,
    parameter int DW = 2
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // No reset: the mask contents are undefined until the writer fills a bank.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/show_mask_overlay.sv
// Overlays a cell-based class mask on an RGB565 stream with a 2-cycle latency.
// Optional grid lines at cell borders are enabled with `define SHOW_MASK_GRID_EN.
module show_mask_overlay
    import show_mask_overlay_pkg::*;
#(
    parameter int P_W     = 11,
    parameter int M_W     = 2,
    parameter int CELL    = 8,
    parameter int GRID_X  = 40,
    parameter int GRID_Y  = 30,
    parameter int WIN_X1  = 0,
    parameter int WIN_Y1  = 0,
    // Frame geometry defaults to the sensor; reduced-size builds may override it.
    parameter int FRAME_X = OV5640_X,
    parameter int FRAME_Y = OV5640_Y
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       i_mvalid,
    input  logic [M_W-1:0]             i_mdata,
    input  logic                       i_mlast,
    input  logic                       i_valid,
    input  logic [15:0]                i_data,
    input  logic [1:0]                 i_mode,
    input  logic [(2**M_W-1)*16-1:0]   i_pal,
    output logic                       o_valid,
    output logic [15:0]                o_data,
    output logic [15:0]                o_data_raw,
    output logic                       o_werr,
    output logic                       o_bank
);

    localparam int NCLS   = 2**M_W - 1;
    localparam int NCELL  = GRID_X * GRID_Y;
    localparam int CA_W   = $clog2(NCELL + 1);
    localparam int CW     = $clog2(CELL);
    localparam int WIN_X2 = WIN_X1 + GRID_X * CELL - 1;
    localparam int WIN_Y2 = WIN_Y1 + GRID_Y * CELL - 1;
    localparam logic [CA_W-1:0] NCELL_C = CA_W'(NCELL);
    localparam logic [CA_W-1:0] GX_C    = CA_W'(GRID_X);
    localparam logic [CW-1:0]   CLAST_C = CW'(CELL - 1);

    logic [P_W-1:0]  cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic [CA_W-1:0] cell_q, cell_d, rbase_q, rbase_d, wptr_q, wptr_d;
    logic [CW-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic            bank_q, bank_d, pend_q, pend_d, werr_q, werr_d;
    logic            frame_start, line_end, frame_end, in_x, in_y, in_win, win_xend;
    logic            mlast_evt, swap, rd_bank, wr_en;

    logic               s0_valid_q, s0_win_q;
    logic [15:0]        s0_data_q;
    ovl_mode_e          s0_mode_q;
    logic [NCLS*16-1:0] s0_pal_q;
    logic [M_W-1:0]     cls, pidx;
    logic [15:0]        pal_k;
    logic               o_valid_q;
    logic [15:0]        o_data_q, o_data_d, o_raw_q;
`ifdef SHOW_MASK_GRID_EN
    logic               s0_grid_q;
`endif

    assign frame_start = (cnt_x_q == '0) && (cnt_y_q == '0);
    assign line_end    = (cnt_x_q == P_W'(FRAME_X - 1));
    assign frame_end   = line_end && (cnt_y_q == P_W'(FRAME_Y - 1));
    assign in_x        = (int'(cnt_x_q) >= WIN_X1) && (int'(cnt_x_q) <= WIN_X2);
    assign in_y        = (int'(cnt_y_q) >= WIN_Y1) && (int'(cnt_y_q) <= WIN_Y2);
    assign in_win      = in_x && in_y;
    assign win_xend    = in_y && (int'(cnt_x_q) == WIN_X2);
    assign mlast_evt   = i_mvalid && i_mlast;
    assign swap        = i_valid && frame_start && (pend_q || mlast_evt);
    assign rd_bank     = bank_q ^ swap;
    assign wr_en       = i_mvalid && (wptr_q != NCELL_C);

    // Raster position plus incremental cell address of the current pixel.
    always_comb begin
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        cell_d  = cell_q;
        rbase_d = rbase_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        if (i_valid) begin
            if (line_end) begin
                cnt_x_d = '0;
                cnt_y_d = frame_end ? '0 : cnt_y_q + 1'b1;
            end else begin
                cnt_x_d = cnt_x_q + 1'b1;
            end
            if (frame_end) begin
                cell_d  = '0;
                rbase_d = '0;
                cx_d    = '0;
                cy_d    = '0;
            end else if (win_xend) begin
                cx_d = '0;
                if (cy_q == CLAST_C) begin
                    cy_d    = '0;
                    rbase_d = rbase_q + GX_C;
                    cell_d  = rbase_q + GX_C;
                end else begin
                    cy_d   = cy_q + 1'b1;
                    cell_d = rbase_q;
                end
            end else if (in_win) begin
                if (cx_q == CLAST_C) begin
                    cx_d   = '0;
                    cell_d = cell_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        werr_d = werr_q;
        pend_d = pend_q;
        bank_d = bank_q;
        if (i_mvalid) begin
            if (!wr_en) werr_d = 1'b1;
            if (i_mlast)    wptr_d = '0;
            else if (wr_en) wptr_d = wptr_q + 1'b1;
        end
        // A last-cell strobe on the swap beat is consumed immediately.
        if (swap)           begin bank_d = ~bank_q; pend_d = 1'b0; end
        else if (mlast_evt) pend_d = 1'b1;
    end

    mask_pingpong_ram #(
        .AW (CA_W + 1),
        .DW (M_W)
    ) u_ram (
        .clk_i   (sys_clk),
        .we_i    (wr_en),
        .waddr_i ({~bank_q, wptr_q}),
        .wdata_i (i_mdata),
        .raddr_i ({rd_bank, cell_q}),
        .rdata_o (cls)
    );

    assign pidx  = (cls == '0) ? '0 : cls - 1'b1;
    assign pal_k = s0_pal_q[pidx*16 +: 16];

    always_comb begin
        o_data_d = s0_data_q;
        if (s0_mode_q != MODE_PASS) begin
            if (!s0_win_q)
                o_data_d = 16'h0000;
`ifdef SHOW_MASK_GRID_EN
            else if (s0_grid_q)
                o_data_d = GRID_COLOR;
`endif
            else if (cls == '0)
                o_data_d = (s0_mode_q == MODE_SOLID) ? 16'h0000 : s0_data_q;
            else if (s0_mode_q == MODE_BLEND)
                o_data_d = avg565(s0_data_q, pal_k);
            else
                o_data_d = pal_k;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_x_q    <= '0;
            cnt_y_q    <= '0;
            cell_q     <= '0;
            rbase_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            wptr_q     <= '0;
            werr_q     <= 1'b0;
            pend_q     <= 1'b0;
            bank_q     <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_win_q   <= 1'b0;
            s0_data_q  <= '0;
            s0_mode_q  <= MODE_PASS;
            s0_pal_q   <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_raw_q    <= '0;
`ifdef SHOW_MASK_GRID_EN
            s0_grid_q  <= 1'b0;
`endif
        end else begin
            cnt_x_q    <= cnt_x_d;
            cnt_y_q    <= cnt_y_d;
            cell_q     <= cell_d;
            rbase_q    <= rbase_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            wptr_q     <= wptr_d;
            werr_q     <= werr_d;
            pend_q     <= pend_d;
            bank_q     <= bank_d;
            s0_valid_q <= i_valid;
            s0_win_q   <= in_win;
            s0_data_q  <= i_data;
            s0_mode_q  <= ovl_mode_e'(i_mode);
            s0_pal_q   <= i_pal;
            o_valid_q  <= s0_valid_q;
            o_data_q   <= o_data_d;
            o_raw_q    <= s0_data_q;
`ifdef SHOW_MASK_GRID_EN
            s0_grid_q  <= (cx_q == '0) || (cy_q == '0);
`endif
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_data_raw = o_raw_q;
    assign o_werr     = werr_q;
    assign o_bank     = bank_q;

endmodule

// File: tb/tb_show_mask_overlay.sv
// Directed bench for show_mask_overlay on a reduced 24x16 frame with a 4x3 grid
// of 4-pixel cells placed at (2,1).
module tb_show_mask_overlay;
    import show_mask_overlay_pkg::*;

    localparam int M_W = 2;
    localparam int CELL = 4;
    localparam int GX = 4;
    localparam int GY = 3;
    localparam int WX1 = 2;
    localparam int WY1 = 1;
    localparam int FX = 24;
    localparam int FY = 16;
    localparam int FRM = FX * FY;
    localparam int NCELL = GX * GY;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_mvalid = 1'b0;
    logic [M_W-1:0]    i_mdata = '0;
    logic              i_mlast = 1'b0;
    logic              i_valid = 1'b0;
    logic [15:0]       i_data = '0;
    logic [1:0]        i_mode = 2'd0;
    logic [47:0]       i_pal = {16'hFFFF, 16'h001F, 16'hF800};
    logic              o_valid, o_werr, o_bank;
    logic [15:0]       o_data, o_data_raw;

    int checks = 0;
    int failures = 0;
    int oidx = 0;
    logic [15:0] cap [FRM];
    logic first_bank, mid_bank;

    show_mask_overlay #(
        .P_W(11), .M_W(M_W), .CELL(CELL), .GRID_X(GX), .GRID_Y(GY),
        .WIN_X1(WX1), .WIN_Y1(WY1), .FRAME_X(FX), .FRAME_Y(FY)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .i_mvalid(i_mvalid), .i_mdata(i_mdata), .i_mlast(i_mlast),
        .i_valid(i_valid), .i_data(i_data), .i_mode(i_mode), .i_pal(i_pal),
        .o_valid(o_valid), .o_data(o_data), .o_data_raw(o_data_raw),
        .o_werr(o_werr), .o_bank(o_bank)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) begin
            if (oidx < FRM) cap[oidx] = o_data;
            oidx = oidx + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic mv,
                       input logic [M_W-1:0] md, input logic ml);
        i_valid = v; i_data = d; i_mvalid = mv; i_mdata = md; i_mlast = ml;
        @(posedge clk); #1;
    endtask

    task automatic mwr(input logic [M_W-1:0] md, input logic ml);
        cyc(1'b0, 16'h0, 1'b1, md, ml);
        cyc(1'b0, 16'h0, 1'b0, '0, 1'b0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        cyc(1'b0, 16'h0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [15:0] at(input int x, input int y);
        return cap[y * FX + x];
    endfunction

    task automatic run_frame(input logic [1:0] mode, input bit pos_px,
                             input int mid_idx, input bit start_last);
        int idx;
        logic mv;
        oidx = 0;
        i_mode = mode;
        for (int y = 0; y < FY; y++) begin
            for (int x = 0; x < FX; x++) begin
                idx = y * FX + x;
                mv = (idx == mid_idx) || (idx == 0 && start_last);
                cyc(1'b1, pos_px ? 16'(y * 256 + x) : 16'h07E0, mv, 2'd1, mv);
                if (idx == 0) first_bank = o_bank;
                if (idx == mid_idx) mid_bank = o_bank;
            end
        end
        repeat (3) cyc(1'b0, 16'h0, 1'b0, '0, 1'b0);
        chk("frame_len", oidx, FRM);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_bank", o_bank, 0);
        chk("rst_werr", o_werr, 0);
        rst_n = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, '0, 1'b0);

        // Mid-frame reset after a swap has taken place.
        i_mode = 2'd0;
        mwr(2'd1, 1'b1);
        for (int k = 0; k < 50; k++) cyc(1'b1, 16'(16'h1000 + k), 1'b0, '0, 1'b0);
        chk("pre_rst_bank", o_bank, 1);
        chk("pre_rst_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_raw", o_data_raw, 0);
        chk("midrst_bank", o_bank, 0);
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, '0, 1'b0);
        cyc(1'b1, 16'hABCD, 1'b0, '0, 1'b0);
        chk("lat1_valid", o_valid, 0);
        chk("lat1_data", o_data, 0);
        cyc(1'b0, 16'h0, 1'b0, '0, 1'b0);
        chk("lat2_valid", o_valid, 1);
        chk("lat2_raw", o_data_raw, 16'hABCD);
        chk("lat2_data", o_data, 16'hABCD);
        cyc(1'b0, 16'h0, 1'b0, '0, 1'b0);
        chk("lat3_valid", o_valid, 0);
        reset_pulse();

        // Frame 1: replace mode, only cell 0 carries class 1.
        for (int c = 0; c < NCELL; c++) mwr((c == 0) ? 2'd1 : 2'd0, c == NCELL - 1);
        chk("f1_pend_bank", o_bank, 0);
        run_frame(2'd1, 1'b1, -1, 1'b0);
        chk("f1_swap", first_bank, 1);
        chk("f1_c0a", at(3, 2), 16'hF800);
        chk("f1_c0b", at(5, 4), 16'hF800);
        chk("f1_c1_raw", at(7, 2), 16'h0207);
        chk("f1_last_win", at(17, 12), 16'h0C11);
        chk("f1_out_l", at(1, 2), 16'h0000);
        chk("f1_out_r", at(18, 12), 16'h0000);
        chk("f1_out_b", at(2, 13), 16'h0000);
`ifdef SHOW_MASK_GRID_EN
        chk("f1_grid00", at(2, 1), GRID_COLOR);
        chk("f1_grid45", at(6, 6), GRID_COLOR);
`else
        chk("f1_grid00", at(2, 1), 16'hF800);
        chk("f1_grid45", at(6, 6), 16'h0606);
`endif

        // Frame 2: blend mode, class equals cell column.
        for (int c = 0; c < NCELL; c++) mwr(2'(c % 4), c == NCELL - 1);
        run_frame(2'd2, 1'b0, -1, 1'b0);
        chk("f2_swap", first_bank, 0);
        chk("f2_cls0", at(3, 2), 16'h07E0);
        chk("f2_cls1", at(7, 2), 16'h7BE0);
        chk("f2_cls2", at(11, 2), 16'h03EF);
        chk("f2_cls3", at(15, 2), 16'h7FEF);
        chk("f2_row2", at(7, 10), 16'h7BE0);
        chk("f2_out", at(1, 2), 16'h0000);

        // Frame 3: solid mode, last-cell strobe mid-frame must not swap.
        run_frame(2'd3, 1'b1, 100, 1'b0);
        chk("f3_noswap", first_bank, 0);
        chk("f3_mid_bank", mid_bank, 0);
        chk("f3_end_bank", o_bank, 0);
        chk("f3_cls0", at(3, 2), 16'h0000);
        chk("f3_cls1", at(7, 2), 16'hF800);
        chk("f3_cls2", at(11, 2), 16'h001F);
        chk("f3_cls3", at(15, 10), 16'hFFFF);

        // Frame 4: pending swap lands at frame start; mode 0 passes everything.
        run_frame(2'd0, 1'b1, -1, 1'b0);
        chk("f4_swap", first_bank, 1);
        chk("f4_pass_out", at(20, 13), 16'h0D14);

        // Frame 5: last-cell strobe on the frame-start beat swaps on that beat.
        run_frame(2'd0, 1'b1, -1, 1'b1);
        chk("f5_same_beat", first_bank, 0);
        chk("f5_end_bank", o_bank, 0);

        // Write overflow and stickiness.
        chk("werr_idle", o_werr, 0);
        for (int c = 0; c < NCELL; c++) mwr(2'd2, 1'b0);
        chk("werr_full", o_werr, 0);
        mwr(2'd2, 1'b0);
        chk("werr_over", o_werr, 1);
        mwr(2'd2, 1'b0);
        mwr(2'd2, 1'b0);
        mwr(2'd0, 1'b1);
        chk("werr_sticky", o_werr, 1);
        reset_pulse();
        chk("werr_reset", o_werr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
